core_dmem_resp: RTL and testbench
=================================

# core_dmem_resp

Data-memory responder for the RV32I pipeline core: the target end of the core's single-strobe load/store interface. It accepts one-cycle load or store request pulses and stalls the pipeline through `HCU_DMEM_BUSY` for a programmable access latency. It performs byte-lane-masked writes and byte/halfword/word reads with sign or zero extension from an internal word-organised RAM. It reports completion with a one-cycle done pulse and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- LATENCY, 2: wait cycles between request and response, range 0..15.

Ports:
- CLK  in  1  sole clock, rising edge.
- NRST  in  1  reset, asynchronous, active-low.
- C_ISLOAD_SS  in  1  single-cycle load request pulse.
- C_ISSTORE_SS  in  1  single-cycle store request pulse.
- DMEM_ADDR  in  32  byte address, valid in the request cycle.
- DMEM_WDATA  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- STRB  in  4  lane-aligned byte enables; encodes size for loads and stores.
- ISLOADBS  in  1  byte load is signed.
- ISLOADHWS  in  1  halfword load is signed.
- DMEM_RDATA  out  32  extracted, extended load data.
- HCU_DMEM_BUSY  out  1  access in progress; the pipeline must stall.
- DMEM_DONE  out  1  one-cycle completion pulse.
- DMEM_ERR  out  1  error qualifier, valid with DMEM_DONE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising CLK edge where C_ISLOAD_SS or C_ISSTORE_SS is high, latch ADDR, WDATA, STRB, sign flags and the request type.
  - Go to WAIT if LATENCY>0, else to RESP.
  - Load the wait counter with LATENCY.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 1.
- RESP: perform the access and pulse DMEM_DONE; always go to IDLE next.
- Request pulses arriving outside IDLE are ignored. The initiator must not issue them.
- Legal STRB patterns:
  - byte: 0001/0010/0100/1000.
  - half: 0011 with addr[1:0]=00, or 1100 with addr[1:0]=10.
  - word: 1111 with addr[1:0]=00.
  - The set lanes must match addr[1:0].
- Error conditions: an illegal STRB/address combination, both request strobes high, or word index (ADDR-BASE_ADDR)>>2 ≥ DEPTH_WORDS (unsigned, including ADDR<BASE_ADDR).
- Error response: DMEM_ERR=1 with DMEM_DONE, no RAM write, DMEM_RDATA forced to 0.
- Store in RESP: shift WDATA left by 8*addr[1:0] and write only the lanes set in STRB. DMEM_RDATA is unchanged.
- Load in RESP: read the word and shift right by 8*addr[1:0].
  - byte: sign-extend bit 7 if ISLOADBS, else zero-extend.
  - half: sign-extend bit 15 if ISLOADHWS, else zero-extend.
  - word: pass unchanged.
- The RAM is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, HCU_DMEM_BUSY=0, DMEM_DONE=0, DMEM_ERR=0, DMEM_RDATA=0, counter=0.
- Reset takes effect immediately when NRST falls, including mid-access. A pending store is discarded and no partial write occurs.
- Request sampled at edge e0; HCU_DMEM_BUSY is registered and goes high after e0.
- Busy stays high through WAIT and RESP: exactly LATENCY+1 cycles. It is low in IDLE.
- DMEM_DONE is high for exactly one cycle, the RESP cycle, which starts LATENCY+1 edges after e0.
- DMEM_RDATA and DMEM_ERR update at the edge entering RESP. DMEM_RDATA holds until the next load or error completes.
- The RAM write commits at the edge leaving RESP. A load issued in the next IDLE cycle returns the new data.
- Back-to-back throughput: one access per LATENCY+2 cycles. A request may be asserted in the first IDLE cycle after RESP.

## Test plan
- LATENCY=2: store word 0xDEADBEEF at 0x40, STRB=1111, then load word 0x40. Required: BUSY high 3 cycles each, DONE 3 edges after each request, RDATA=0xDEADBEEF, ERR=0.
- Byte lanes: after the above, store byte 0x80 at 0x41 (STRB=0010), then:
  - signed byte load at 0x41 -> 0xFFFFFF80;
  - unsigned -> 0x00000080;
  - word load -> 0xDEAD80EF.
- Halfword: store 0x8001 at 0x42 (STRB=1100). Required: signed half load at 0x42 -> 0xFFFF8001; unsigned -> 0x00008001.
- Errors, each must give DONE with ERR=1, RDATA=0 and leave memory unchanged:
  - half load at 0x43;
  - word store at 0x42;
  - address BASE_ADDR+4*DEPTH_WORDS;
  - load and store strobes asserted together.
- LATENCY=0: DONE the cycle after the request, BUSY high 1 cycle. A second request pulse while BUSY is ignored: no second DONE.
- NRST asserted during WAIT of a store to 0x40 with data 0x12345678. Required: all outputs 0 immediately, state IDLE; a subsequent word load at 0x40 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/core_dmem_resp.sv
// Data-memory responder for the RV32I core: single-strobe load/store target with a fixed
// access latency, byte-lane writes, sign/zero-extended sub-word reads and error flagging.
module core_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        C_ISLOAD_SS,
  input  logic        C_ISSTORE_SS,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic [3:0]  STRB,
  input  logic        ISLOADBS,
  input  logic        ISLOADHWS,
  output logic [31:0] DMEM_RDATA,
  output logic        HCU_DMEM_BUSY,
  output logic        DMEM_DONE,
  output logic        DMEM_ERR
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        bs_q, bs_d, hs_q, hs_d, ld_q, ld_d, st_q, st_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        enter_resp;
  logic [31:0] a_addr;
  logic [3:0]  a_strb;
  logic        a_bs, a_hs, a_ld, a_st;
  logic [31:0] off, word_off;
  logic [AW-1:0] widx;
  logic        lane_ok, range_ok, a_err;
  logic [4:0]  shamt;
  logic [31:0] rword, shifted, ld_data, wsh;

  assign req = C_ISLOAD_SS | C_ISSTORE_SS;

  // With LATENCY=0 the access is resolved at the request edge, so use the live request in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      a_addr = DMEM_ADDR;
      a_strb = STRB;
      a_bs   = ISLOADBS;
      a_hs   = ISLOADHWS;
      a_ld   = C_ISLOAD_SS;
      a_st   = C_ISSTORE_SS;
    end else begin
      a_addr = addr_q;
      a_strb = strb_q;
      a_bs   = bs_q;
      a_hs   = hs_q;
      a_ld   = ld_q;
      a_st   = st_q;
    end
  end

  always_comb begin
    off      = a_addr - BASE_ADDR;
    word_off = off >> 2;
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    range_ok = word_off < DEPTH_WORDS;
    widx     = off[AW+1:2];
    case (a_strb)
      4'b0001: lane_ok = (a_addr[1:0] == 2'd0);
      4'b0010: lane_ok = (a_addr[1:0] == 2'd1);
      4'b0100: lane_ok = (a_addr[1:0] == 2'd2);
      4'b1000: lane_ok = (a_addr[1:0] == 2'd3);
      4'b0011: lane_ok = (a_addr[1:0] == 2'd0);
      4'b1100: lane_ok = (a_addr[1:0] == 2'd2);
      4'b1111: lane_ok = (a_addr[1:0] == 2'd0);
      default: lane_ok = 1'b0;
    endcase
    a_err   = !lane_ok || !range_ok || (a_ld && a_st);
    shamt   = {a_addr[1:0], 3'b000};
    rword   = mem[widx];
    shifted = rword >> shamt;
    case (a_strb)
      4'b1111:         ld_data = shifted;
      4'b0011, 4'b1100: ld_data = a_hs ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'h0000, shifted[15:0]};
      default:         ld_data = a_bs ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h000000, shifted[7:0]};
    endcase
    wsh = wdata_q << shamt;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    bs_d       = bs_q;
    hs_d       = hs_q;
    ld_d       = ld_q;
    st_d       = st_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = DMEM_ADDR;
          wdata_d = DMEM_WDATA;
          strb_d  = STRB;
          bs_d    = ISLOADBS;
          hs_d    = ISLOADHWS;
          ld_d    = C_ISLOAD_SS;
          st_d    = C_ISSTORE_SS;
          busy_d  = 1'b1;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      done_d = 1'b1;
      err_d  = a_err;
      if (a_err) begin
        rdata_d = 32'h0;
      end else if (a_ld) begin
        rdata_d = ld_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      bs_q    <= 1'b0;
      hs_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      bs_q    <= bs_d;
      hs_q    <= hs_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Commit on the edge leaving RESP; reset forces IDLE so an aborted store never writes.
  always_ff @(posedge CLK) begin
    if (state_q == StResp && st_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem[widx][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

  assign DMEM_RDATA    = rdata_q;
  assign HCU_DMEM_BUSY = busy_q;
  assign DMEM_DONE     = done_q;
  assign DMEM_ERR      = err_q;

endmodule

// File: tb/tb_core_dmem_resp.sv
// Scoreboard bench for core_dmem_resp: one instance at LATENCY=2 and one at LATENCY=0.
module tb_core_dmem_resp;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        ld2 = 0, st2 = 0, bs2 = 0, hs2 = 0;
  logic [31:0] a2 = 0, wd2 = 0;
  logic [3:0]  sb2 = 0;
  logic [31:0] rd2;
  logic        busy2, done2, err2;

  logic        ld0 = 0, st0 = 0, bs0 = 0, hs0 = 0;
  logic [31:0] a0 = 0, wd0 = 0;
  logic [3:0]  sb0 = 0;
  logic [31:0] rd0;
  logic        busy0, done0, err0;

  int tests = 0;
  int fails = 0;
  exp_t q2[$];
  exp_t q0[$];
  logic [31:0] hold2 = 0, hold0 = 0;

  core_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut2 (
    .CLK(clk), .NRST(nrst), .C_ISLOAD_SS(ld2), .C_ISSTORE_SS(st2), .DMEM_ADDR(a2),
    .DMEM_WDATA(wd2), .STRB(sb2), .ISLOADBS(bs2), .ISLOADHWS(hs2), .DMEM_RDATA(rd2),
    .HCU_DMEM_BUSY(busy2), .DMEM_DONE(done2), .DMEM_ERR(err2)
  );

  core_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
    .CLK(clk), .NRST(nrst), .C_ISLOAD_SS(ld0), .C_ISSTORE_SS(st0), .DMEM_ADDR(a0),
    .DMEM_WDATA(wd0), .STRB(sb0), .ISLOADBS(bs0), .ISLOADHWS(hs0), .DMEM_RDATA(rd0),
    .HCU_DMEM_BUSY(busy0), .DMEM_DONE(done0), .DMEM_ERR(err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitors: pop the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      exp_t e;
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL lat2 unexpected done: rdata=%h err=%b", rd2, err2);
      end else begin
        e = q2.pop_front();
        if (rd2 !== e.rd || err2 !== e.err) begin
          fails++;
          $display("FAIL lat2 resp#%0d: rdata=%h err=%b want rdata=%h err=%b",
                   e.id, rd2, err2, e.rd, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      exp_t e;
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL lat0 unexpected done: rdata=%h err=%b", rd0, err0);
      end else begin
        e = q0.pop_front();
        if (rd0 !== e.rd || err0 !== e.err) begin
          fails++;
          $display("FAIL lat0 resp#%0d: rdata=%h err=%b want rdata=%h err=%b",
                   e.id, rd0, err0, e.rd, e.err);
        end
      end
    end
  end

  task automatic drive(input bit sel, input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sb, input bit bs, input bit hs);
    if (sel) begin
      ld0 = ld; st0 = st; a0 = a; wd0 = wd; sb0 = sb; bs0 = bs; hs0 = hs;
    end else begin
      ld2 = ld; st2 = st; a2 = a; wd2 = wd; sb2 = sb; bs2 = bs; hs2 = hs;
    end
  endtask

  // Issue one access from a negedge in IDLE; returns at the negedge after busy drops.
  task automatic acc(input bit sel, input bit ld, input bit st, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] sb, input bit bs, input bit hs,
                     input logic [31:0] exp_rd, input bit exp_err, input int id);
    exp_t e;
    int lat;
    int busy_n;
    int done_at;
    logic [31:0] want;
    lat = sel ? 0 : 2;
    if (exp_err) want = 32'h0;
    else if (ld) want = exp_rd;
    else want = sel ? hold0 : hold2;
    if (sel) hold0 = want; else hold2 = want;
    e.rd = want; e.err = exp_err; e.id = 8'(id);
    if (sel) q0.push_back(e); else q2.push_back(e);
    drive(sel, ld, st, a, wd, sb, bs, hs);
    @(posedge clk);
    #1;
    drive(sel, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    busy_n = 0;
    done_at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(sel ? busy0 : busy2)) break;
      busy_n++;
      if (sel ? done0 : done2) done_at = k;
    end
    check($sformatf("busy_cycles#%0d", id), 32'(busy_n), 32'(lat + 1));
    check($sformatf("done_edge#%0d", id), 32'(done_at), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_busy2", {31'b0, busy2}, 32'd0);
    check("reset_done2", {31'b0, done2}, 32'd0);
    check("reset_err2", {31'b0, err2}, 32'd0);
    check("reset_rdata2", rd2, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // LATENCY=2 directed vectors
    acc(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0, 0, 1);
    acc(0, 1, 0, 32'h40, 32'h0, 4'b1111, 0, 0, 32'hDEADBEEF, 0, 2);
    acc(0, 0, 1, 32'h41, 32'h00000080, 4'b0010, 0, 0, 32'h0, 0, 3);
    acc(0, 1, 0, 32'h41, 32'h0, 4'b0010, 1, 0, 32'hFFFFFF80, 0, 4);
    acc(0, 1, 0, 32'h41, 32'h0, 4'b0010, 0, 0, 32'h00000080, 0, 5);
    acc(0, 1, 0, 32'h40, 32'h0, 4'b1111, 0, 0, 32'hDEAD80EF, 0, 6);
    acc(0, 0, 1, 32'h42, 32'h00008001, 4'b1100, 0, 0, 32'h0, 0, 7);
    acc(0, 1, 0, 32'h42, 32'h0, 4'b1100, 0, 1, 32'hFFFF8001, 0, 8);
    acc(0, 1, 0, 32'h42, 32'h0, 4'b1100, 0, 0, 32'h00008001, 0, 9);
    acc(0, 0, 1, 32'h0, 32'hA5A5A5A5, 4'b1111, 0, 0, 32'h0, 0, 10);
    // Error cases
    acc(0, 1, 0, 32'h43, 32'h0, 4'b1100, 0, 0, 32'h0, 1, 11);
    acc(0, 0, 1, 32'h42, 32'hCAFEF00D, 4'b1111, 0, 0, 32'h0, 1, 12);
    acc(0, 0, 1, 32'h1000, 32'h11111111, 4'b1111, 0, 0, 32'h0, 1, 13);
    acc(0, 1, 1, 32'h40, 32'h0BADF00D, 4'b1111, 0, 0, 32'h0, 1, 14);
    acc(0, 1, 0, 32'h40, 32'h0, 4'b1111, 0, 0, 32'h800180EF, 0, 15);
    acc(0, 1, 0, 32'h0, 32'h0, 4'b1111, 0, 0, 32'hA5A5A5A5, 0, 16);

    // LATENCY=0 instance
    acc(1, 0, 1, 32'h8, 32'h11223344, 4'b1111, 0, 0, 32'h0, 0, 20);
    acc(1, 1, 0, 32'h8, 32'h0, 4'b1111, 0, 0, 32'h11223344, 0, 21);
    acc(1, 1, 0, 32'hA, 32'h0, 4'b1100, 0, 0, 32'h00001122, 0, 22);
    // Request held into the RESP cycle: the second pulse must be ignored.
    begin
      exp_t e;
      e.rd = 32'h00000044; e.err = 0; e.id = 8'd23;
      hold0 = e.rd;
      q0.push_back(e);
      drive(1, 1, 0, 32'h8, 32'h0, 4'b0001, 0, 0);
      @(posedge clk);
      #1;
      check("lat0_busy_resp", {31'b0, busy0}, 32'd1);
      drive(1, 1, 0, 32'h9, 32'h0, 4'b0001, 0, 0);
      @(posedge clk);
      #1;
      drive(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
      check("lat0_ignored_busy", {31'b0, busy0}, 32'd0);
      repeat (3) @(negedge clk);
    end
    acc(1, 1, 0, 32'hB, 32'h0, 4'b1000, 1, 0, 32'h00000011, 0, 24);

    // Reset during WAIT of a store to 0x40
    drive(0, 0, 1, 32'h40, 32'h12345678, 4'b1111, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    check("wait_busy_before_rst", {31'b0, busy2}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy2}, 32'd0);
    check("rst_mid_done", {31'b0, done2}, 32'd0);
    check("rst_mid_err", {31'b0, err2}, 32'd0);
    check("rst_mid_rdata", rd2, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    hold2 = 32'h0;
    hold0 = 32'h0;
    repeat (3) @(negedge clk);
    acc(0, 1, 0, 32'h40, 32'h0, 4'b1111, 0, 0, 32'h800180EF, 0, 30);

    repeat (4) @(negedge clk);
    check("lat2_queue_empty", 32'(q2.size()), 32'd0);
    check("lat0_queue_empty", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
